btb_update_ctrl: RTL and testbench

- Sequences all writes into the branch target buffer arrays (tag, valid, target, LRU) on behalf of the resolve stage.
- Resolved-branch update requests are buffered in a small FIFO and drained through a write FSM.
- BTB lookups from the IF stage take priority over writes to the single-ported arrays.
- Sits between the resolve stage and the BTB datapath, replacing the free-running BTB write control.

---
 rtl/btb_update_ctrl.sv | 122 ++++++++++++
 tb/tb_btb_update_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: buffers resolved-branch updates in a FIFO and drains them
// into the tag/valid/target/LRU arrays, yielding the array port to IF lookups.
module btb_update_ctrl #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_valid,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_btb_hit,
  input  logic              upd_way,
  input  logic              lookup_active,
  input  logic              flush,
  output logic              load_tag,
  output logic              load_valid,
  output logic              load_target,
  output logic              load_lru,
  output logic              lru_store,
  output logic [WORD_W-1:0] wr_pc,
  output logic [WORD_W-1:0] wr_target,
  output logic              wr_way,
  output logic              stall,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WR_TAG, WR_TGT, WR_LRU} state_t;
  state_t state, state_nxt;

  logic [WORD_W-1:0] mem_pc  [DEPTH];
  logic [WORD_W-1:0] mem_tgt [DEPTH];
  logic              mem_hit [DEPTH];
  logic              mem_way [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [2:0]    starve_cnt;
  logic          lru_last;
  logic          full, pop, push, starved, wr_ok;

  assign full    = (count == CW'(DEPTH));
  assign stall   = full;
  assign starved = full && (starve_cnt == 3'd7);
  assign wr_ok   = !lookup_active || starved;
  // Pop is decided before push, so a full FIFO still accepts a push on a pop cycle
  assign pop     = (state == IDLE) && (count != '0) && !flush;
  assign push    = upd_valid && !flush && (!full || pop);

  always_comb begin
    state_nxt   = state;
    load_tag    = 1'b0;
    load_valid  = 1'b0;
    load_target = 1'b0;
    load_lru    = 1'b0;
    lru_store   = 1'b0;
    case (state)
      IDLE:   if (pop) state_nxt = mem_hit[rd_ptr] ? WR_TGT : WR_TAG;
      WR_TAG: if (wr_ok) begin
        load_tag   = 1'b1;
        load_valid = 1'b1;
        state_nxt  = WR_TGT;
      end
      WR_TGT: if (wr_ok) begin
        load_target = 1'b1;
        state_nxt   = WR_LRU;
      end
      WR_LRU: if (wr_ok) begin
        load_lru  = 1'b1;
        lru_store = wr_way;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]  <= upd_pc;
      mem_tgt[wr_ptr] <= upd_target;
      mem_hit[wr_ptr] <= upd_btb_hit;
      mem_way[wr_ptr] <= upd_way;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      starve_cnt <= '0;
      lru_last   <= 1'b0;
      wr_pc      <= '0;
      wr_target  <= '0;
      wr_way     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
      if (upd_valid && !flush && full && !pop) overflow <= 1'b1;
      if (pop) begin
        wr_pc     <= mem_pc[rd_ptr];
        wr_target <= mem_tgt[rd_ptr];
        // No victim info for misses: allocate the way opposite the last one used
        wr_way    <= mem_hit[rd_ptr] ? mem_way[rd_ptr] : ~lru_last;
      end
      if (load_lru) lru_last <= wr_way;
      if (!full || load_lru)       starve_cnt <= '0;
      else if (starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed table-driven bench for btb_update_ctrl plus a reset-mid-sequence check.
module tb_btb_update_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid, upd_btb_hit, upd_way, lookup_active, flush;
  logic [15:0] upd_pc, upd_target;
  logic        load_tag, load_valid, load_target, load_lru, lru_store;
  logic [15:0] wr_pc, wr_target;
  logic        wr_way, stall, overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  btb_update_ctrl #(.DEPTH(4), .WORD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_btb_hit(upd_btb_hit), .upd_way(upd_way),
    .lookup_active(lookup_active), .flush(flush), .load_tag(load_tag),
    .load_valid(load_valid), .load_target(load_target), .load_lru(load_lru),
    .lru_store(lru_store), .wr_pc(wr_pc), .wr_target(wr_target), .wr_way(wr_way),
    .stall(stall), .overflow(overflow)
  );

  typedef struct packed {
    logic [4:0]  ld;   // {tag, valid, target, lru, lru_store}
    logic [15:0] wpc;
    logic [15:0] wtg;
    logic        wway;
    logic        st;
    logic        ov;
  } outs_t;

  typedef struct {
    logic        v;
    logic [15:0] pc;
    logic [15:0] tg;
    logic        hit;
    logic        way;
    logic        lk;
    logic        fl;
    outs_t       exp;
  } vec_t;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] TAG  = 5'b11000;
  localparam logic [4:0] TGT  = 5'b00100;
  localparam logic [4:0] LRU0 = 5'b00010;
  localparam logic [4:0] LRU1 = 5'b00011;

  vec_t vecs[$];

  function automatic outs_t actual();
    return {load_tag, load_valid, load_target, load_lru, lru_store,
            wr_pc, wr_target, wr_way, stall, overflow};
  endfunction

  task automatic add(input logic v, input logic [15:0] pc, input logic [15:0] tg,
                     input logic hit, input logic way, input logic lk, input logic fl,
                     input logic [4:0] ld, input logic [15:0] wpc, input logic [15:0] wtg,
                     input logic wway, input logic st, input logic ov);
    vec_t r;
    r.v = v; r.pc = pc; r.tg = tg; r.hit = hit; r.way = way; r.lk = lk; r.fl = fl;
    r.exp = '{ld: ld, wpc: wpc, wtg: wtg, wway: wway, st: st, ov: ov};
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input outs_t got, input outs_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got ld=%b pc=%h tg=%h way=%b st=%b ov=%b, want ld=%b pc=%h tg=%h way=%b st=%b ov=%b",
               name, got.ld, got.wpc, got.wtg, got.wway, got.st, got.ov,
               want.ld, want.wpc, want.wtg, want.wway, want.st, want.ov);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] tg,
                       input logic hit, input logic way, input logic lk, input logic fl);
    upd_valid = v; upd_pc = pc; upd_target = tg; upd_btb_hit = hit;
    upd_way = way; lookup_active = lk; flush = fl;
  endtask

  initial begin
    // miss, hit, lookup-deferred write with three updates queued behind it
    add(1, 16'h3000, 16'h3040, 0, 0, 0, 0, NONE, 16'h0000, 16'h0000, 0, 0, 0); // v0
    add(0, 0, 0, 0, 0, 0, 0, NONE, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, TAG,  16'h3000, 16'h3040, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, TGT,  16'h3000, 16'h3040, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, LRU1, 16'h3000, 16'h3040, 1, 0, 0);
    add(1, 16'h3010, 16'h3050, 1, 1, 0, 0, NONE, 16'h3000, 16'h3040, 1, 0, 0); // v5
    add(0, 0, 0, 0, 0, 0, 0, NONE, 16'h3000, 16'h3040, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, TGT,  16'h3010, 16'h3050, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, LRU1, 16'h3010, 16'h3050, 1, 0, 0);
    add(1, 16'h3100, 16'h3140, 0, 0, 0, 0, NONE, 16'h3010, 16'h3050, 1, 0, 0); // v9
    add(0, 0, 0, 0, 0, 0, 0, NONE, 16'h3010, 16'h3050, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, TAG,  16'h3100, 16'h3140, 0, 0, 0);
    add(1, 16'h3200, 16'h3240, 0, 0, 1, 0, NONE, 16'h3100, 16'h3140, 0, 0, 0); // v12 lookup
    add(1, 16'h3300, 16'h3340, 0, 0, 0, 0, TGT,  16'h3100, 16'h3140, 0, 0, 0);
    add(1, 16'h3400, 16'h3440, 0, 0, 0, 0, LRU0, 16'h3100, 16'h3140, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, NONE, 16'h3100, 16'h3140, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, TAG,  16'h3200, 16'h3240, 1, 0, 0);               // v16 flush
    add(0, 0, 0, 0, 0, 0, 0, TGT,  16'h3200, 16'h3240, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, LRU1, 16'h3200, 16'h3240, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, NONE, 16'h3200, 16'h3240, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, NONE, 16'h3200, 16'h3240, 1, 0, 0);
    // fill under continuous lookups, overflow, then starvation override
    add(1, 16'h4000, 16'h5000, 0, 0, 1, 0, NONE, 16'h3200, 16'h3240, 1, 0, 0); // v21
    add(1, 16'h4010, 16'h5001, 0, 0, 1, 0, NONE, 16'h3200, 16'h3240, 1, 0, 0);
    add(1, 16'h4020, 16'h5002, 0, 0, 1, 0, NONE, 16'h4000, 16'h5000, 0, 0, 0);
    add(1, 16'h4030, 16'h5003, 0, 0, 1, 0, NONE, 16'h4000, 16'h5000, 0, 0, 0);
    add(1, 16'h4040, 16'h5004, 0, 0, 1, 0, NONE, 16'h4000, 16'h5000, 0, 0, 0);
    add(1, 16'h4050, 16'h5005, 0, 0, 1, 0, NONE, 16'h4000, 16'h5000, 0, 1, 0); // v26 dropped
    for (int i = 0; i < 6; i++)
      add(0, 0, 0, 0, 0, 1, 0, NONE, 16'h4000, 16'h5000, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, TAG,  16'h4000, 16'h5000, 0, 1, 1);               // v33 override
    add(0, 0, 0, 0, 0, 1, 0, TGT,  16'h4000, 16'h5000, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, LRU0, 16'h4000, 16'h5000, 0, 1, 1);
    add(1, 16'h6000, 16'h6006, 0, 0, 1, 0, NONE, 16'h4000, 16'h5000, 0, 1, 1); // v36 push+pop full
    add(0, 0, 0, 0, 0, 1, 0, NONE, 16'h4010, 16'h5001, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, TAG,  16'h4010, 16'h5001, 1, 1, 1);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", actual(), '{ld: NONE, wpc: 16'h0, wtg: 16'h0, wway: 0, st: 0, ov: 0});
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].v, vecs[i].pc, vecs[i].tg, vecs[i].hit, vecs[i].way, vecs[i].lk, vecs[i].fl);
      @(negedge clk);
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
    end

    // Reset asserted in the middle of WR_TGT
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 16'h7000, 16'h7040, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_reset_wr_tgt", actual(),
          '{ld: TGT, wpc: 16'h7000, wtg: 16'h7040, wway: 1, st: 0, ov: 0});
    #1 rst_n = 1'b0;
    #1 check("async_reset", actual(), '{ld: NONE, wpc: 16'h0, wtg: 16'h0, wway: 0, st: 0, ov: 0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("post_reset%0d", c), actual(),
            '{ld: NONE, wpc: 16'h0, wtg: 16'h0, wway: 0, st: 0, ov: 0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
